regfile_preloader: RTL and testbench

REGFILE_PRELOADER -- requirements
Module: regfile_preloader

---
 rtl/regfile_preloader.sv | 157 +++++++++++++++
 tb/tb_regfile_preloader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_preloader.sv
// Streams (index, value) entries into a register file through its test port while holding the
// processor in reset. Optional readback checking is enabled by defining REGFILE_VERIFY_EN.
module regfile_preloader #(
  parameter int unsigned MAX_WRITES = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [4:0]  in_addr,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        test,
  output logic        t_ctrl_writeEnable,
  output logic [4:0]  t_ctrl_writeReg,
  output logic [31:0] t_data_writeReg,
  output logic [4:0]  t_ctrl_readRegA,
  input  logic [31:0] t_data_readRegA,
  output logic        proc_hold,
  output logic        done,
  output logic        err,
  output logic [6:0]  write_count
);

`ifdef REGFILE_VERIFY_EN
  typedef enum logic [1:0] {StIdle, StLoad, StCheck, StDone} state_e;
`else
  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;
`endif

  localparam logic [6:0] LastCnt = 7'(MAX_WRITES - 1);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [4:0]  wreg_q, wreg_d;
  logic [31:0] wdata_q, wdata_d;
  logic [6:0]  count_q, count_d;
  logic        err_q, err_d;
  // fin_q: the final entry (in_last or overflow) has been accepted
  logic        fin_q, fin_d;
  logic        accept;

`ifdef REGFILE_VERIFY_EN
  // pend_q: the cycle right after an acceptance (write cycle)
  logic        pend_q, pend_d;
  assign in_ready = (state_q == StLoad) && !fin_q && !pend_q;
`else
  logic        unused_rd;
  assign unused_rd = ^t_data_readRegA;
  assign in_ready  = (state_q == StLoad) && !fin_q;
`endif

  assign accept = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    count_d = count_q;
    err_d   = err_q;
    fin_d   = fin_q;
`ifdef REGFILE_VERIFY_EN
    pend_d  = 1'b0;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StLoad;
          count_d = '0;
          err_d   = 1'b0;
          fin_d   = 1'b0;
        end
      end
      StLoad: begin
`ifdef REGFILE_VERIFY_EN
        if (pend_q) begin
          if (we_q) begin
            state_d = StCheck;
          end else if (fin_q) begin
            state_d = StDone;
          end
        end else
`endif
        if (fin_q) begin
          state_d = StDone;
        end else if (accept) begin
          count_d = count_q + 7'd1;
`ifdef REGFILE_VERIFY_EN
          pend_d  = 1'b1;
`endif
          if (in_addr != 5'd0) begin
            we_d    = 1'b1;
            wreg_d  = in_addr;
            wdata_d = in_data;
          end
          if (in_last) begin
            fin_d = 1'b1;
          end else if (count_q == LastCnt) begin
            err_d = 1'b1;
            fin_d = 1'b1;
          end
        end
      end
`ifdef REGFILE_VERIFY_EN
      StCheck: begin
        // Regfile read is combinational; the write landed at the end of the write cycle
        if (t_data_readRegA != wdata_q) err_d = 1'b1;
        state_d = fin_q ? StDone : StLoad;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      fin_q   <= 1'b0;
`ifdef REGFILE_VERIFY_EN
      pend_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      err_q   <= err_d;
      fin_q   <= fin_d;
`ifdef REGFILE_VERIFY_EN
      pend_q  <= pend_d;
`endif
    end
  end

  assign test               = (state_q != StIdle) && (state_q != StDone);
  assign proc_hold          = (state_q != StDone);
  assign done               = (state_q == StDone);
  assign err                = err_q;
  assign write_count        = count_q;
  assign t_ctrl_writeEnable = we_q;
  assign t_ctrl_writeReg    = wreg_q;
  assign t_data_writeReg    = wdata_q;
`ifdef REGFILE_VERIFY_EN
  assign t_ctrl_readRegA    = (state_q == StCheck) ? wreg_q : 5'd0;
`else
  assign t_ctrl_readRegA    = 5'd0;
`endif

endmodule

// File: tb/tb_regfile_preloader.sv
// Scoreboard bench for regfile_preloader: the driver queues expected writes, a negedge monitor
// checks every regfile write for address, data and one-cycle latency.
module tb_regfile_preloader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [4:0]  in_addr = '0;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        in_ready, test, t_ctrl_writeEnable, proc_hold, done, err;
  logic [4:0]  t_ctrl_writeReg, t_ctrl_readRegA;
  logic [31:0] t_data_writeReg, t_data_readRegA;
  logic [6:0]  write_count;

  regfile_preloader #(.MAX_WRITES(64)) dut (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_addr(in_addr),
    .in_data(in_data), .in_last(in_last), .in_ready(in_ready), .test(test),
    .t_ctrl_writeEnable(t_ctrl_writeEnable), .t_ctrl_writeReg(t_ctrl_writeReg),
    .t_data_writeReg(t_data_writeReg), .t_ctrl_readRegA(t_ctrl_readRegA),
    .t_data_readRegA(t_data_readRegA), .proc_hold(proc_hold), .done(done), .err(err),
    .write_count(write_count)
  );

  always #5 clock = ~clock;

  // Regfile model with an optional fault that reads r3 as zero
  logic [31:0] rf [32];
  logic        fault_r3 = 1'b0;
  initial for (int i = 0; i < 32; i++) rf[i] = '0;
  always @(posedge clock) if (t_ctrl_writeEnable) rf[t_ctrl_writeReg] <= t_data_writeReg;
  always_comb begin
    t_data_readRegA = rf[t_ctrl_readRegA];
    if (fault_r3 && t_ctrl_readRegA == 5'd3) t_data_readRegA = '0;
  end

  typedef struct {logic [4:0] a; logic [31:0] d; int c;} exp_t;
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   nwrites = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: every write must match the oldest outstanding expected entry
  always @(negedge clock) begin
    if (reset && t_ctrl_writeEnable) begin
      exp_t e;
      nwrites++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL spurious_write actual=r%0d/0x%0h required=none", t_ctrl_writeReg,
                 t_data_writeReg);
      end else begin
        e = exp_q.pop_front();
        if (t_ctrl_writeReg !== e.a || t_data_writeReg !== e.d || cyc != e.c) begin
          errors++;
          $display("FAIL write actual=r%0d/0x%0h@%0d required=r%0d/0x%0h@%0d", t_ctrl_writeReg,
                   t_data_writeReg, cyc, e.a, e.d, e.c);
        end
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Present an entry at a negedge; returns at the negedge after it is accepted
  task automatic send(input logic [4:0] a, input logic [31:0] d, input logic l);
    int n = 0;
    in_valid = 1'b1; in_addr = a; in_data = d; in_last = l;
    while (!in_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
    end else if (a != 5'd0) begin
      exp_q.push_back('{a: a, d: d, c: cyc + 1});
    end
    @(negedge clock);
  endtask

  task automatic idle();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 20) begin
      @(negedge clock);
      n++;
    end
    check(name, 32'(done), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_proc_hold"}, 32'(proc_hold), 32'd1);
    check({tag, "_test"}, 32'(test), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_we"}, 32'(t_ctrl_writeEnable), 32'd0);
    check({tag, "_wreg"}, 32'(t_ctrl_writeReg), 32'd0);
    check({tag, "_wdata"}, t_data_writeReg, 32'd0);
    check({tag, "_rdreg"}, 32'(t_ctrl_readRegA), 32'd0);
    check({tag, "_done_err_cnt"}, {done, err, write_count}, 32'd0);
  endtask

  initial begin
    int base;
    int blocked;
    repeat (2) @(negedge clock);
    check_reset_outputs("rst");
    reset = 1'b1;
    @(negedge clock);
    check("idle_test", 32'(test), 32'd0);

    // Three back-to-back entries ending with last
    pulse_start();
    check("load_test", 32'(test), 32'd1);
    send(5'd1, 32'd65535, 1'b0);
    send(5'd2, 32'd7, 1'b0);
    send(5'd31, 32'hDEADBEEF, 1'b1);
    idle();
    check("last_ready_low", 32'(in_ready), 32'd0);
    wait_done("t1_done");
    check("t1_proc_hold", 32'(proc_hold), 32'd0);
    check("t1_test", 32'(test), 32'd0);
    check("t1_count", 32'(write_count), 32'd3);
    check("t1_err", 32'(err), 32'd0);

    // Zero index entry: counted, never written
    pulse_start();
    check("restart_clears", {29'd0, done, err, 1'b0} | 32'(write_count), 32'd0);
    send(5'd0, 32'd5, 1'b1);
    idle();
    wait_done("t2_done");
    check("t2_count", 32'(write_count), 32'd1);
    check("t2_err", 32'(err), 32'd0);

    // Overflow: 64 entries without last, 65th must be refused
    base = nwrites;
    pulse_start();
    for (int i = 0; i < 64; i++) send(5'(i % 31 + 1), 32'(i * 3 + 100), 1'b0);
    in_valid = 1'b1; in_addr = 5'd9; in_data = 32'd999; in_last = 1'b0;
    blocked = 0;
    repeat (5) begin
      if (in_ready) blocked++;
      @(negedge clock);
    end
    check("ovf_65th_refused", 32'(blocked), 32'd0);
    idle();
    wait_done("ovf_done");
    check("ovf_err", 32'(err), 32'd1);
    check("ovf_count", 32'(write_count), 32'd64);
    check("ovf_writes", 32'(nwrites - base), 32'd64);

    // Valid gaps: no writes, still loading; start in LOAD ignored
    pulse_start();
    send(5'd5, 32'h55, 1'b0);
    idle();
    repeat (3) begin
      @(negedge clock);
      check("gap_test", {31'd0, test}, 32'd1);
      check("gap_done", {31'd0, done}, 32'd0);
    end
    pulse_start();
    check("start_in_load_ignored", 32'(write_count), 32'd1);
    send(5'd6, 32'h66, 1'b1);
    idle();
    wait_done("gap_done_final");
    check("gap_count", 32'(write_count), 32'd2);

    // Reset right after acceptance of (4,9): write must never appear
    pulse_start();
    in_valid = 1'b1; in_addr = 5'd4; in_data = 32'd9; in_last = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;
    #1 check_reset_outputs("midrst");
    idle();
    @(negedge clock);
    reset = 1'b1;
    repeat (4) @(negedge clock);
    check("post_rst_idle", {proc_hold, test, in_ready, done}, 32'b1000);
    check("post_rst_no_r4", rf[4] == 32'd9 && nwrites > 0 ? 32'd1 : 32'd0, 32'd0);

`ifdef REGFILE_VERIFY_EN
    begin
      logic saw_rd3;
      fault_r3 = 1'b1;
      pulse_start();
      send(5'd3, 32'd12, 1'b1);
      idle();
      saw_rd3 = (t_ctrl_readRegA == 5'd3);
      wait_done("vfy_bad_done");
      check("vfy_readreg", 32'(saw_rd3), 32'd1);
      check("vfy_bad_err", 32'(err), 32'd1);
      fault_r3 = 1'b0;
      pulse_start();
      send(5'd3, 32'd12, 1'b1);
      idle();
      wait_done("vfy_good_done");
      check("vfy_good_err", 32'(err), 32'd0);
    end
`endif

    repeat (3) @(negedge clock);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
